// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
// Turns the data cache's memory-side request/ready ports into a single-outstanding
// AXI4 master. It serves line refills, dirty write-backs and uncached single-beat accesses.
// Optional feature macro: DCACHE_AXI_BRIDGE_ERR_EN enables the sticky bus_err_o flag.
// When the macro is undefined, bus_err_o is tied low and responses are not checked.
module dcache_axi_bridge #(
    parameter int                  AXI_ID_W = 4,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    // cache read port
    input  logic [31:0]         raddr_i,
    input  logic                raddr_valid_i,
    input  logic [3:0]          rsize_i,
    input  logic [7:0]          rlen_i,
    input  logic [7:0]          rmask_i,
    output logic                rdata_ready_o,
    output logic [63:0]         rdata_o,
    // cache write port
    input  logic [31:0]         waddr_i,
    input  logic                waddr_valid_i,
    input  logic [3:0]          wsize_i,
    input  logic [7:0]          wlen_i,
    input  logic [7:0]          wmask_i,
    input  logic [63:0]         wdata_i,
    output logic                wdata_ready_o,
    // AXI AW
    output logic [AXI_ID_W-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    // AXI W
    output logic [63:0]         wdata,
    output logic [7:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // AXI B
    input  logic [AXI_ID_W-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // AXI AR
    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    // AXI R
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [63:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // status
    output logic                bus_err_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_AR     = 4'd1,
        ST_R      = 4'd2,
        ST_AW     = 4'd3,
        ST_W_DATA = 4'd4,
        ST_W_WAIT = 4'd5,
        ST_W_LOAD = 4'd6,
        ST_B      = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] addr_r;
    logic [7:0]  len_r;
    logic [2:0]  size_r;
    logic [7:0]  beat_r;
    logic [63:0] wdata_r;
    logic [7:0]  wstrb_r;
    logic        last_beat_s;
    logic        unused_s;

    // One-hot byte count to AXI size code; anything unexpected is treated as a full 8-byte beat.
    function automatic logic [2:0] size_to_axsize(input logic [3:0] size);
        case (size)
            4'b0001: size_to_axsize = 3'd0;
            4'b0010: size_to_axsize = 3'd1;
            4'b0100: size_to_axsize = 3'd2;
            4'b1000: size_to_axsize = 3'd3;
            default: size_to_axsize = 3'd3;
        endcase
    endfunction

    assign last_beat_s = (beat_r == len_r);

    // Address/control comes straight from registers, so it is stable while valid waits for ready.
    assign awid    = AXI_ID;
    assign awaddr  = addr_r;
    assign awlen   = len_r;
    assign awsize  = size_r;
    assign awburst = 2'b01;
    assign arid    = AXI_ID;
    assign araddr  = addr_r;
    assign arlen   = len_r;
    assign arsize  = size_r;
    assign arburst = 2'b01;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wlast   = (state_r == ST_W_DATA) && last_beat_s;
    assign rdata_o = rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and per-state handshake outputs.
    always_comb begin
        state_nx_s    = state_r;
        arvalid       = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        rready        = 1'b0;
        rdata_ready_o = 1'b0;
        wdata_ready_o = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (waddr_valid_i) begin
                    state_nx_s = ST_AW;
                end else if (raddr_valid_i) begin
                    state_nx_s = ST_AR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nx_s = ST_R;
                end else begin
                    state_nx_s = ST_AR;
                end
            end
            ST_R: begin
                rready        = 1'b1;
                rdata_ready_o = rvalid;
                if (rvalid && rlast) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_R;
                end
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_nx_s = ST_W_DATA;
                end else begin
                    state_nx_s = ST_AW;
                end
            end
            ST_W_DATA: begin
                wvalid = 1'b1;
                if (wready) begin
                    if (last_beat_s) begin
                        // The final pulse is held back until the write response arrives.
                        state_nx_s = ST_B;
                    end else begin
                        wdata_ready_o = 1'b1;
                        state_nx_s    = ST_W_WAIT;
                    end
                end else begin
                    state_nx_s = ST_W_DATA;
                end
            end
            ST_W_WAIT: begin
                // Gives the cache's synchronous data array a cycle to present the next beat.
                state_nx_s = ST_W_LOAD;
            end
            ST_W_LOAD: begin
                state_nx_s = ST_W_DATA;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wdata_ready_o = 1'b1;
                    state_nx_s    = ST_DONE;
                end else begin
                    state_nx_s = ST_B;
                end
            end
            ST_DONE: begin
                // Lets the cache's registered request valid drop before IDLE samples it again.
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request capture in IDLE, beat counting and write-beat reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 32'd0;
            len_r   <= 8'd0;
            size_r  <= 3'd0;
            beat_r  <= 8'd0;
            wdata_r <= 64'd0;
            wstrb_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    beat_r <= 8'd0;
                    if (waddr_valid_i) begin
                        addr_r  <= waddr_i;
                        len_r   <= wlen_i;
                        size_r  <= size_to_axsize(wsize_i);
                        wdata_r <= wdata_i;
                        wstrb_r <= wmask_i;
                    end else if (raddr_valid_i) begin
                        addr_r <= raddr_i;
                        len_r  <= rlen_i;
                        size_r <= size_to_axsize(rsize_i);
                    end
                end
                ST_R: begin
                    // Read beats are counted too, so rlast can be cross-checked against len.
                    if (rvalid) begin
                        beat_r <= beat_r + 8'd1;
                    end
                end
                ST_W_DATA: begin
                    if (wready && !last_beat_s) begin
                        beat_r <= beat_r + 8'd1;
                    end
                end
                ST_W_LOAD: begin
                    wdata_r <= wdata_i;
                    wstrb_r <= wmask_i;
                end
                default: begin
                    beat_r <= beat_r;
                end
            endcase
        end
    end

`ifdef DCACHE_AXI_BRIDGE_ERR_EN
    logic bus_err_r;
    logic rd_err_s;
    logic wr_err_s;

    assign rd_err_s  = (state_r == ST_R) && rvalid && ((rresp != 2'b00) || (rlast != last_beat_s));
    assign wr_err_s  = (state_r == ST_B) && bvalid && (bresp != 2'b00);
    assign bus_err_o = bus_err_r;
    assign unused_s  = ^{rmask_i, bid, rid};

    // Sticky error flag; only reset clears it, the transaction itself completes normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_r <= 1'b0;
        end else if (rd_err_s || wr_err_s) begin
            bus_err_r <= 1'b1;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end
`else
    assign bus_err_o = 1'b0;
    assign unused_s  = ^{rmask_i, bid, rid, rresp, bresp};
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: a small AXI slave and cache-side model
// driven from one per-cycle task, with scoreboard queues for read and write beats.
module tb_dcache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr_i, waddr_i;
    logic        raddr_valid_i, waddr_valid_i;
    logic [3:0]  rsize_i, wsize_i;
    logic [7:0]  rlen_i, rmask_i, wlen_i, wmask_i;
    logic [63:0] wdata_i;
    logic        rdata_ready_o, wdata_ready_o;
    logic [63:0] rdata_o;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready, bus_err_o;
    logic [63:0] wdata, rdata;

    always #5 clk = ~clk;

    dcache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .raddr_i(raddr_i), .raddr_valid_i(raddr_valid_i), .rsize_i(rsize_i), .rlen_i(rlen_i),
        .rmask_i(rmask_i), .rdata_ready_o(rdata_ready_o), .rdata_o(rdata_o),
        .waddr_i(waddr_i), .waddr_valid_i(waddr_valid_i), .wsize_i(wsize_i), .wlen_i(wlen_i),
        .wmask_i(wmask_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bus_err_o(bus_err_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] exp_r[$];
    logic [72:0] exp_w[$];   // {wlast, wstrb, wdata}

    // slave model state
    int          ar_delay, ar_cnt, r_idx, r_len;
    bit          r_active, b_pend;
    logic [63:0] r_words[8];
    logic [1:0]  rresp_val, bresp_val;
    int          stall_beat, stall_cycles, stall_cnt, w_beat, b_delay, b_cnt;
    logic [31:0] ar_exp_addr;
    logic [7:0]  ar_exp_len;
    // observations
    logic [31:0] ar_addr_seen, aw_addr_seen;
    logic [7:0]  ar_len_seen, aw_len_seen;
    logic [2:0]  ar_size_seen, aw_size_seen;
    logic [5:0]  ar_idb_seen, aw_idb_seen;   // {id, burst}
    int          ar_hs_cyc, aw_hs_cyc;
    // cache model
    logic [63:0] wline[8];
    logic [7:0]  wmline[8];
    int          w_pulses, w_total, r_pulses, r_first_cyc, r_last_cyc;
    int          w_first_cyc, w_last_cyc, w_hs_n, wpulse_cyc, stalls_seen;

`ifdef DCACHE_AXI_BRIDGE_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic clear_model();
        ar_delay = 0; ar_cnt = 0; r_idx = 0; r_len = 0; r_active = 0; b_pend = 0;
        rresp_val = 2'b00; bresp_val = 2'b00;
        stall_beat = -1; stall_cycles = 0; stall_cnt = 0; w_beat = 0; b_delay = 0; b_cnt = 0;
        w_pulses = 0; w_total = 0; r_pulses = 0; w_hs_n = 0; stalls_seen = 0;
        ar_hs_cyc = -1; aw_hs_cyc = -1; wpulse_cyc = -1;
        exp_r.delete(); exp_w.delete();
    endtask

    // One clock cycle: drive slave inputs at the falling edge, sample 1 ns later, update models.
    task automatic tick();
        @(negedge clk);
        cyc++;
        arready = arvalid && (ar_cnt >= ar_delay);
        awready = awvalid;
        rvalid  = r_active;
        rdata   = r_active ? r_words[r_idx] : 64'd0;
        rlast   = r_active && (r_idx == r_len);
        rresp   = r_active ? rresp_val : 2'b00;
        rid     = 4'd1;
        wready  = !((w_beat == stall_beat) && (stall_cnt < stall_cycles));
        bvalid  = b_pend && (b_cnt >= b_delay);
        bresp   = bvalid ? bresp_val : 2'b00;
        bid     = 4'd1;
        #1;
        if (rdata_ready_o) begin
            logic [63:0] e;
            checks++;
            if (exp_r.size() == 0) begin
                errors++; $display("FAIL rd_beat unexpected pulse got %h", rdata_o);
            end else begin
                e = exp_r.pop_front();
                if (rdata_o !== e) begin errors++; $display("FAIL rd_beat got %h exp %h", rdata_o, e); end
            end
            if (r_pulses == 0) r_first_cyc = cyc;
            r_last_cyc = cyc;
            r_pulses++;
        end
        if (wvalid && wready) begin
            logic [72:0] e;
            checks++;
            if (exp_w.size() == 0) begin
                errors++; $display("FAIL wr_beat unexpected beat got %h", wdata);
            end else begin
                e = exp_w.pop_front();
                if ({wlast, wstrb, wdata} !== e) begin
                    errors++; $display("FAIL wr_beat got %h exp %h", {wlast, wstrb, wdata}, e);
                end
            end
            if (w_hs_n == 0) w_first_cyc = cyc;
            w_last_cyc = cyc;
            w_hs_n++;
        end
        if (wvalid && !wready) begin
            stalls_seen++;
            checks++;
            if (exp_w.size() == 0 || {wlast, wstrb, wdata} !== exp_w[0] || wdata_ready_o !== 1'b0) begin
                errors++; $display("FAIL wr_stall got %h pulse %b", {wlast, wstrb, wdata}, wdata_ready_o);
            end
        end
        if (wdata_ready_o) begin
            checks++;
            if (bvalid !== (w_pulses == w_total - 1)) begin
                errors++; $display("FAIL wr_pulse_timing pulse %0d bvalid %b", w_pulses, bvalid);
            end
            w_pulses++;
            wpulse_cyc = cyc;
            if (w_pulses < 8) begin
                wdata_i = wline[w_pulses];
                wmask_i = wmline[w_pulses];
            end
        end
        if (arvalid && !arready) begin
            checks++;
            if (araddr !== ar_exp_addr || arlen !== ar_exp_len) begin
                errors++; $display("FAIL ar_stable got %h/%0d exp %h/%0d", araddr, arlen, ar_exp_addr, ar_exp_len);
            end
        end
        // slave bookkeeping
        if (arvalid && arready) begin
            ar_addr_seen = araddr; ar_len_seen = arlen; ar_size_seen = arsize;
            ar_idb_seen = {arid, arburst}; ar_hs_cyc = cyc;
            ar_cnt = 0; r_active = 1; r_idx = 0; r_len = int'(arlen);
        end else if (arvalid) begin
            ar_cnt++;
        end
        if (awvalid && awready) begin
            aw_addr_seen = awaddr; aw_len_seen = awlen; aw_size_seen = awsize;
            aw_idb_seen = {awid, awburst}; aw_hs_cyc = cyc;
        end
        if (rvalid && rready) begin
            if (rlast) r_active = 0;
            else r_idx++;
        end
        if (wvalid && wready) begin
            if (wlast) begin b_pend = 1; b_cnt = 0; end
            w_beat++;
        end else if (wvalid) begin
            stall_cnt++;
        end
        if (bvalid && bready) b_pend = 0;
        else if (b_pend) b_cnt++;
    endtask

    // Fill the cache line model and scoreboard, then raise the write request.
    task automatic start_write(input logic [31:0] addr, input int len, input logic [63:0] seed);
        for (int i = 0; i < 8; i++) begin
            wline[i]  = seed + 64'(i) * 64'h0101_0101_0101_0101;
            wmline[i] = 8'hF0 | 8'(i);
        end
        for (int i = 0; i <= len; i++) exp_w.push_back({i == len, wmline[i], wline[i]});
        w_pulses = 0; w_total = len + 1; w_beat = 0; stall_cnt = 0; w_hs_n = 0;
        waddr_i = addr; wsize_i = 4'b1000; wlen_i = 8'(len);
        wdata_i = wline[0]; wmask_i = wmline[0];
        waddr_valid_i = 1'b1;
    endtask

    task automatic start_read(input logic [31:0] addr, input int len, input logic [3:0] size);
        for (int i = 0; i <= len; i++) exp_r.push_back(r_words[i]);
        r_pulses = 0;
        ar_exp_addr = addr; ar_exp_len = 8'(len);
        raddr_i = addr; rlen_i = 8'(len); rsize_i = size; rmask_i = 8'hFF;
        raddr_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raddr_valid_i = 0; waddr_valid_i = 0; raddr_i = 0; waddr_i = 0;
        rsize_i = 0; wsize_i = 0; rlen_i = 0; wlen_i = 0; rmask_i = 0; wmask_i = 0; wdata_i = 0;
        clear_model();
        repeat (3) tick();
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, rdata_ready_o, wdata_ready_o, bus_err_o} !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle got %b exp 00000000",
                     {arvalid, awvalid, wvalid, rready, bready, rdata_ready_o, wdata_ready_o, bus_err_o});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        clear_model();
        ar_delay = 2;
        r_words[0] = 64'h1122_3344_5566_7788;
        start_read(32'hA000_0048, 0, 4'b0100);
        tick();
        raddr_i = 32'hDEAD_BEEF;   // must be ignored outside IDLE
        for (int i = 0; i < 50 && r_pulses < 1; i++) tick();
        raddr_valid_i = 1'b0;
        checks++;
        if (r_pulses != 1) begin errors++; $display("FAIL single_read pulses got %0d exp 1", r_pulses); end
        checks++;
        if ({ar_addr_seen, ar_len_seen, ar_size_seen, ar_idb_seen} !== {32'hA000_0048, 8'd0, 3'd2, 4'd1, 2'b01}) begin
            errors++;
            $display("FAIL single_read_ar got %h %0d %0d %h", ar_addr_seen, ar_len_seen, ar_size_seen, ar_idb_seen);
        end
        tick();
        checks++;
        if ({arvalid, rready, rdata_ready_o} !== 3'b000) begin
            errors++; $display("FAIL single_read_done got %b exp 000", {arvalid, rready, rdata_ready_o});
        end
        repeat (3) tick();
        checks++;
        if (r_pulses != 1 || exp_r.size() != 0) begin
            errors++; $display("FAIL single_read_tail pulses %0d left %0d exp 1/0", r_pulses, exp_r.size());
        end
    endtask

    task automatic test_refill();
        int t;
        clear_model();
        for (int i = 0; i < 8; i++) r_words[i] = 64'(i);
        start_read(32'h8000_0040, 7, 4'b1000);
        t = cyc;
        for (int i = 0; i < 60 && r_pulses < 8; i++) tick();
        raddr_valid_i = 1'b0;
        checks++;
        if (ar_hs_cyc != t + 1 || r_first_cyc != t + 2 || r_last_cyc != t + 9 || r_pulses != 8) begin
            errors++;
            $display("FAIL refill_timing ar %0d first %0d last %0d n %0d exp %0d %0d %0d 8",
                     ar_hs_cyc - t, r_first_cyc - t, r_last_cyc - t, r_pulses, 1, 2, 9);
        end
        checks++;
        if ({ar_addr_seen, ar_len_seen, ar_size_seen} !== {32'h8000_0040, 8'd7, 3'd3}) begin
            errors++; $display("FAIL refill_ar got %h %0d %0d", ar_addr_seen, ar_len_seen, ar_size_seen);
        end
        repeat (2) tick();
    endtask

    task automatic test_writeback();
        clear_model();
        b_delay = 5;
        start_write(32'h8000_1000, 7, 64'hD0D0_0000_0000_0000);
        for (int i = 0; i < 200 && w_pulses < 8; i++) tick();
        waddr_valid_i = 1'b0;
        checks++;
        if (w_pulses != 8 || exp_w.size() != 0) begin
            errors++; $display("FAIL writeback_count pulses %0d left %0d exp 8/0", w_pulses, exp_w.size());
        end
        checks++;
        if ({aw_addr_seen, aw_len_seen, aw_size_seen, aw_idb_seen} !== {32'h8000_1000, 8'd7, 3'd3, 4'd1, 2'b01}) begin
            errors++;
            $display("FAIL writeback_aw got %h %0d %0d %h", aw_addr_seen, aw_len_seen, aw_size_seen, aw_idb_seen);
        end
        checks++;
        if (w_last_cyc - w_first_cyc != 21) begin
            errors++; $display("FAIL writeback_rate span %0d exp 21", w_last_cyc - w_first_cyc);
        end
        repeat (2) tick();
    endtask

    task automatic test_simultaneous();
        clear_model();
        r_words[0] = 64'hCAFE_F00D_0000_0001;
        start_write(32'h9000_0000, 0, 64'h5555_0000_0000_0000);
        start_read(32'h9000_0100, 0, 4'b0100);
        for (int i = 0; i < 50 && w_pulses < 1; i++) tick();
        waddr_valid_i = 1'b0;
        for (int i = 0; i < 50 && r_pulses < 1; i++) tick();
        raddr_valid_i = 1'b0;
        checks++;
        if (w_pulses != 1 || r_pulses != 1) begin
            errors++; $display("FAIL simul_count w %0d r %0d exp 1/1", w_pulses, r_pulses);
        end
        checks++;
        if (aw_hs_cyc < 0 || aw_hs_cyc >= ar_hs_cyc || ar_hs_cyc != wpulse_cyc + 3) begin
            errors++;
            $display("FAIL simul_order aw %0d ar %0d wpulse %0d exp ar=wpulse+3", aw_hs_cyc, ar_hs_cyc, wpulse_cyc);
        end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        clear_model();
        stall_beat = 2; stall_cycles = 4;
        start_write(32'h8000_2000, 7, 64'h0BAD_0000_0000_0000);
        for (int i = 0; i < 200 && w_pulses < 8; i++) tick();
        waddr_valid_i = 1'b0;
        checks++;
        if (stalls_seen != 4 || w_pulses != 8 || exp_w.size() != 0) begin
            errors++;
            $display("FAIL backpressure stalls %0d pulses %0d left %0d exp 4/8/0", stalls_seen, w_pulses, exp_w.size());
        end
        repeat (2) tick();
    endtask

    task automatic test_errors();
        clear_model();
        bresp_val = 2'b10;
        start_write(32'h9000_0040, 0, 64'h7777_0000_0000_0000);
        for (int i = 0; i < 50 && w_pulses < 1; i++) tick();
        waddr_valid_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus_err_o !== EXP_ERR) begin errors++; $display("FAIL err_set got %b exp %b", bus_err_o, EXP_ERR); end
        clear_model();
        r_words[0] = 64'h1234;
        start_read(32'h9000_0080, 0, 4'b1000);
        for (int i = 0; i < 50 && r_pulses < 1; i++) tick();
        raddr_valid_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus_err_o !== EXP_ERR || r_pulses != 1) begin
            errors++; $display("FAIL err_sticky got %b n %0d exp %b 1", bus_err_o, r_pulses, EXP_ERR);
        end
        // reset in the middle of a burst abandons it and clears the flag
        clear_model();
        start_write(32'h9000_0100, 7, 64'h4444_0000_0000_0000);
        for (int i = 0; i < 50 && w_beat < 2; i++) tick();
        rst = 1'b1;
        waddr_valid_i = 1'b0;
        tick();
        checks++;
        if ({awvalid, wvalid, bready, wdata_ready_o, bus_err_o} !== 5'd0) begin
            errors++;
            $display("FAIL err_reset got %b exp 00000", {awvalid, wvalid, bready, wdata_ready_o, bus_err_o});
        end
        rst = 1'b0;
        clear_model();
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_refill();
        test_writeback();
        test_simultaneous();
        test_backpressure();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
